// File: rtl/seq_shift_unit_pkg.sv
// Shared ALU definitions for the shift/rotate unit: opcodes, flag positions,
// FSM states and a constant clog2 helper.
package seq_shift_unit_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational slice of the shifter: moves a value by 0..STEP positions and
// reports the last bit out plus any LSL sign change seen along the way.
module shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int W    = 16,
    parameter int STEP = 1,
    parameter int AW   = clog2(STEP) + 1
) (
    input  logic [W-1:0]  value,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amount,
    input  logic          orig_msb,
    output logic [W-1:0]  shifted,
    output logic          carry,
    output logic          overflow
);

    // Unrolled chain of single-bit moves so V sees every intermediate MSB.
    always_comb begin
        shifted  = value;
        carry    = 1'b0;
        overflow = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (AW'(i) < amount) begin
                case (mode)
                    OP_LSL: begin
                        carry    = shifted[W-1];
                        shifted  = {shifted[W-2:0], 1'b0};
                        overflow = overflow | (shifted[W-1] != orig_msb);
                    end
                    OP_LSR: begin
                        carry   = shifted[0];
                        shifted = {1'b0, shifted[W-1:1]};
                    end
                    OP_ASR: begin
                        carry   = shifted[0];
                        shifted = {shifted[W-1], shifted[W-1:1]};
                    end
                    OP_ROL: begin
                        shifted = {shifted[W-2:0], shifted[W-1]};
                        carry   = shifted[0];
                    end
                    OP_ROR: begin
                        shifted = {shifted[0], shifted[W-1:1]};
                        carry   = shifted[W-1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: decodes the signed amount on start, then walks
// the operand STEP positions per cycle and registers result/flags on completion.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   shift_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    localparam int LW = clog2(W);
    localparam int CW = LW + 1;
    localparam int AW = clog2(STEP) + 1;

    state_e         state;
    logic [W-1:0]   work;
    logic [2:0]     mode;
    logic [CW-1:0]  cnt;
    logic           orig_msb;
    logic           v_acc;

    logic [W-1:0]   mag;
    logic [2:0]     eff_mode;
    logic [CW-1:0]  cnt_init;
    logic [AW-1:0]  step_amt;
    logic [CW-1:0]  cnt_next;
    logic [W-1:0]   step_val;
    logic           step_c;
    logic           step_v;

    function automatic logic [3:0] make_flags(input logic [W-1:0] value,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = value[W-1];
        f[FLAG_Z] = (value == '0);
        return f;
    endfunction

    // A negative amount flips direction; ASR has no right-to-left twin, so it becomes LSL.
    always_comb begin
        mag      = operandB[W-1] ? -operandB : operandB;
        eff_mode = shift_op;
        if (operandB[W-1]) begin
            case (shift_op)
                OP_LSL:  eff_mode = OP_LSR;
                OP_LSR:  eff_mode = OP_LSL;
                OP_ASR:  eff_mode = OP_LSL;
                OP_ROL:  eff_mode = OP_ROR;
                OP_ROR:  eff_mode = OP_ROL;
                default: eff_mode = shift_op;
            endcase
        end
        case (eff_mode)
            OP_LSL, OP_LSR, OP_ASR: cnt_init = (mag >= W'(W)) ? CW'(W) : mag[CW-1:0];
            OP_ROL, OP_ROR:         cnt_init = {1'b0, mag[LW-1:0]};
            default:                cnt_init = '0;
        endcase
    end

    always_comb begin
        step_amt = (cnt > CW'(STEP)) ? AW'(STEP) : AW'(cnt);
        cnt_next = cnt - CW'(step_amt);
    end

    shift_step #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .value    (work),
        .mode     (mode),
        .amount   (step_amt),
        .orig_msb (orig_msb),
        .shifted  (step_val),
        .carry    (step_c),
        .overflow (step_v)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            mode     <= OP_LSL;
            cnt      <= '0;
            orig_msb <= 1'b0;
            v_acc    <= 1'b0;
            result   <= '0;
            flags    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work     <= operandA;
                        mode     <= eff_mode;
                        cnt      <= cnt_init;
                        orig_msb <= operandA[W-1];
                        v_acc    <= 1'b0;
                        busy     <= 1'b1;
                        if (cnt_init == '0) begin
                            result <= operandA;
                            flags  <= make_flags(operandA, 1'b0, 1'b0);
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    work  <= step_val;
                    cnt   <= cnt_next;
                    v_acc <= v_acc | step_v;
                    if (cnt_next == '0) begin
                        result <= step_val;
                        flags  <= make_flags(step_val, step_c, v_acc | step_v);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: a STEP=1 and a STEP=4 instance checked every cycle
// against a transaction-level model, plus hand-computed literal results.
module tb_seq_shift_unit;
    import seq_shift_unit_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start    [2];
    logic [2:0]   shift_op [2];
    logic [W-1:0] opa      [2];
    logic [W-1:0] opb      [2];
    logic [W-1:0] res      [2];
    logic [3:0]   flg      [2];
    logic         busy     [2];
    logic         done     [2];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int           m_rem  [2];
    bit           m_busy [2];
    bit           m_done [2];
    logic [W-1:0] m_res  [2];
    logic [3:0]   m_flg  [2];
    logic [W-1:0] p_res  [2];
    logic [3:0]   p_flg  [2];

    always #5 clk = ~clk;

    seq_shift_unit #(.W(W), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .shift_op(shift_op[0]),
        .operandA(opa[0]), .operandB(opb[0]), .result(res[0]), .flags(flg[0]),
        .busy(busy[0]), .done(done[0])
    );

    seq_shift_unit #(.W(W), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .shift_op(shift_op[1]),
        .operandA(opa[1]), .operandB(opb[1]), .result(res[1]), .flags(flg[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Whole-operation arithmetic reference: final value, flags and position count.
    function automatic void model_op(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] r_out,
                                     output logic [3:0] f_out, output int n);
        bit neg, c, v, mb;
        int m, ai, si, r;
        logic [2:0] e;
        logic [W-1:0] rv;
        neg = b[W-1];
        m   = neg ? (1 << W) - int'(b) : int'(b);
        e   = op;
        if (neg) begin
            case (op)
                3'd0: e = 3'd1;
                3'd1: e = 3'd0;
                3'd2: e = 3'd0;
                3'd3: e = 3'd4;
                3'd4: e = 3'd3;
                default: e = op;
            endcase
        end
        ai = int'(a);
        c = 1'b0; v = 1'b0; n = 0; r = ai;
        case (e)
            3'd0: begin
                n = (m > W) ? W : m;
                r = ai << n;
                for (int j = 1; j <= n; j++) begin
                    mb = 1'b0;
                    if (j < W) mb = a[W-1-j];
                    if (mb != a[W-1]) v = 1'b1;
                end
                if (n > 0) c = a[W-n];
            end
            3'd1: begin
                n = (m > W) ? W : m;
                r = ai >> n;
                if (n > 0) c = a[n-1];
            end
            3'd2: begin
                n  = (m > W) ? W : m;
                si = a[W-1] ? ai - (1 << W) : ai;
                r  = si >>> n;
                if (n > 0) c = a[n-1];
            end
            3'd3: begin
                n = m % W;
                r = (ai << n) | (ai >> (W - n));
            end
            3'd4: begin
                n = m % W;
                r = (ai >> n) | (ai << (W - n));
            end
            default: begin
                n = 0;
                r = ai;
            end
        endcase
        rv = r[W-1:0];
        if (e == 3'd3 && n > 0) c = rv[0];
        if (e == 3'd4 && n > 0) c = rv[W-1];
        r_out = rv;
        f_out = {v, c, rv[W-1], (rv == '0)};
    endfunction

    // Cycle timing from the handshake rules: accept in idle, ceil(n/STEP) work cycles, one done cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n, cyc, stp;
            stp = (i == 0) ? 1 : 4;
            if (!rst_n) begin
                m_rem[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
                m_res[i] = '0; m_flg[i] = '0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_done[i] = 1'b1; m_res[i] = p_res[i]; m_flg[i] = p_flg[i];
                end
            end else if (m_done[i]) begin
                m_done[i] = 1'b0; m_busy[i] = 1'b0;
            end else if (!m_busy[i] && start[i]) begin
                model_op(shift_op[i], opa[i], opb[i], p_res[i], p_flg[i], n);
                cyc = (n + stp - 1) / stp;
                m_busy[i] = 1'b1;
                if (cyc == 0) begin
                    m_done[i] = 1'b1; m_res[i] = p_res[i]; m_flg[i] = p_flg[i];
                end else begin
                    m_rem[i] = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (busy[i] !== m_busy[i] || done[i] !== m_done[i] ||
                    res[i] !== m_res[i] || flg[i] !== m_flg[i]) begin
                    errors++;
                    $display("[TB] FAIL cycle_model dut%0d t=%0t: got busy=%b done=%b result=%h flags=%b, want busy=%b done=%b result=%h flags=%b",
                             i, $time, busy[i], done[i], res[i], flg[i],
                             m_busy[i], m_done[i], m_res[i], m_flg[i]);
                end
            end
        end
    end

    task automatic applyStimulus(input int i, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        shift_op[i] = op; opa[i] = a; opb[i] = b; start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        shift_op[i] = 3'b001; opa[i] = ~a; opb[i] = b ^ 16'h0003;
    endtask

    task automatic waitDone(input int i, output int cycles);
        cycles = 0;
        while (!done[i] && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        if (!done[i]) begin
            checks++; errors++;
            $display("[TB] FAIL done_timeout dut%0d: got done=%b after %0d cycles, want done=1", i, done[i], cycles);
        end
    endtask

    task automatic checkOutput(input string name, input int i, input logic [W-1:0] er,
                               input logic [3:0] ef, input int elat, input int lat);
        checks++;
        if (res[i] !== er || flg[i] !== ef) begin
            errors++;
            $display("[TB] FAIL %s: got result=%h flags=%b, want result=%h flags=%b", name, res[i], flg[i], er, ef);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles, want %0d", name, lat, elat);
        end
    endtask

    task automatic checkIdle(input string name);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || res[i] !== '0 || flg[i] !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL %s dut%0d: got busy=%b done=%b result=%h flags=%b, want all zero",
                         name, i, busy[i], done[i], res[i], flg[i]);
            end
        end
    endtask

    task automatic runOp(input string name, input int i, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef, input int elat);
        int cyc;
        applyStimulus(i, op, a, b);
        waitDone(i, cyc);
        checkOutput(name, i, er, ef, elat, cyc + 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; shift_op[i] = '0; opa[i] = '0; opb[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        checkIdle("reset_state");
        rst_n = 1'b1;

        runOp("rol_5",        0, OP_ROL, 16'd32,   16'd5,    16'd1024, 4'b0000, 6);
        runOp("rol_neg3",     0, OP_ROL, 16'hFFF3, 16'hFFFD, 16'h7FFE, 4'b0000, 4);
        runOp("asr_2",        0, OP_ASR, 16'hFFF3, 16'd2,    16'hFFFC, 4'b0110, 3);
        runOp("lsl_clamp",    0, OP_LSL, 16'd16,   16'd20,   16'h0000, 4'b1001, 17);
        runOp("rol_mod",      0, OP_ROL, 16'h00F0, 16'd20,   16'h0F00, 4'b0000, 5);
        runOp("s4_lsr_15",    1, OP_LSR, 16'h8000, 16'd15,   16'h0001, 4'b0000, 5);
        runOp("s4_lsr_0",     1, OP_LSR, 16'h1234, 16'd0,    16'h1234, 4'b0000, 1);
        runOp("s4_illegal",   1, 3'b111, 16'h8000, 16'd3,    16'h8000, 4'b0010, 1);
        runOp("s4_ror_1",     1, OP_ROR, 16'h0001, 16'd1,    16'h8000, 4'b0110, 2);
        runOp("s4_asr_minb",  1, OP_ASR, 16'h0001, 16'h8000, 16'h0000, 4'b1101, 5);

        // Start pulses while busy and during the done cycle must both be dropped.
        applyStimulus(0, OP_ROL, 16'd32, 16'd5);
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b1; shift_op[0] = OP_LSL; opa[0] = 16'd1; opb[0] = 16'd1;
        @(negedge clk);
        start[0] = 1'b0;
        waitDone(0, cyc);
        checkOutput("start_in_run", 0, 16'd1024, 4'b0000, 6, cyc + 4);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || res[0] !== 16'd1024) begin
            errors++;
            $display("[TB] FAIL start_in_done: got busy=%b result=%h, want busy=0 result=0400", busy[0], res[0]);
        end

        applyStimulus(0, OP_LSL, 16'd16, 16'd20);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdle("reset_mid_run");
        rst_n = 1'b1;

        runOp("after_reset",  0, OP_ROL, 16'd32,   16'd5,    16'd1024, 4'b0000, 6);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle, parametrised shift/rotate execution unit for the ALU datapath. It replaces the single-cycle rotate-left path.
- Supports five shift/rotate modes and signed shift amounts; a negative amount reverses direction.
- Processes STEP bit positions per cycle with a start/busy/done handshake, so wide operands do not need a full barrel shifter.
- Produces a result and a 4-bit flag vector in the same encoding as the ALU.

Parameters:
- W, 16, operand/result width; power of two, >= 4.
- STEP, 1, bit positions shifted per RUN cycle; 1 <= STEP <= W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- shift_op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, others illegal.
- operandA  input  W  value to shift.
- operandB  input  W  signed shift amount.
- result  output  W  shifted value; holds until next accepted start.
- flags  output  4  {V,C,N,Z}: [3]=V, [2]=C, [1]=N, [0]=Z.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, coincident with a valid result/flags.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; result=0, flags=0, busy=0, done=0. Applies mid-operation and aborts it; no partial result is kept.
- States are IDLE, RUN, DONE.
- IDLE + start at edge k:
  - Latch operandA, shift_op, dir, cnt.
  - Go to RUN if cnt>0, else DONE.
- Direction: operandB<0 swaps the mode: LSL<->LSR, ASR->LSL, ROL<->ROR. Magnitude m=|operandB|; the most-negative value gives 2^(W-1).
- Count:
  - Shifts: cnt=min(m,W).
  - Rotates: cnt=m mod W.
  - Counter width clog2(W)+1.
- RUN: each cycle shifts by s=min(STEP,cnt); cnt-=s. When cnt reaches 0, go to DONE.
- Fill bits: LSL/LSR fill with 0. ASR fills with the latched sign. Rotates wrap.
- DONE: done=1 for exactly one cycle, then IDLE.
  - result/flags update on the edge entering DONE.
  - busy drops on the edge leaving DONE.
- Latency: start at edge k -> done high during cycle after edge k+1+ceil(cnt/STEP). cnt=0 -> done after edge k+1.
- start while busy: ignored, no queueing. start in the DONE cycle: also ignored.
- Flags, computed on the final value:
  - Z: result==0.
  - N: result[W-1].
  - C: last bit shifted or rotated out. For ROL this is the new result[0]; for ROR the new result[W-1]; 0 if cnt=0.
  - V: sticky, LSL only. Set if MSB differed from the original MSB after any single-bit position. 0 for all other modes.
- Illegal shift_op: result=operandA, C=V=0, Z/N computed; done after edge k+1.
- Operand inputs may change after acceptance without effect.

Decomposition:
- Shared alu package holds:
  - shift_op encodings.
  - Flag bit indices (FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0).
  - State enum {IDLE,RUN,DONE}.
  - clog2 function.
- One natural sub-module, shift_step: combinational. Shifts a W-bit value by 0..STEP positions in a given mode and returns the value, last-out bit and V contribution. seq_shift_unit holds the FSM, counter and registers.

Test Plan:
- W=16, STEP=1, ROL, A=32, B=5 -> result=1024, flags=0000, done 6 cycles after the start edge, busy high throughout.
- ROL, A=-13 (0xFFF3), B=-3 (acts as ROR 3) -> result=0x7FFE, C=0, N=0, Z=0.
- ASR, A=-13, B=2 -> result=-4 (0xFFFC), C=1, N=1.
- LSL, A=16, B=20 (clamped to 16) -> result=0, Z=1, C=0, V=1, 16 RUN cycles.
- STEP=4 instance, LSR, A=0x8000, B=15 -> result=0x0001, C=0, 4 RUN cycles; B=0 -> result=A, done after edge k+1.
- Control cases:
  - start pulsed during RUN -> ignored, first result unchanged.
  - rst_n=0 mid-RUN -> next edge busy=0, done=0, result=0, flags=0.
  - Next start after reset completes normally.
